// File: rtl/clk_period_meter_if.sv
// Bundle of the measurement request and result signals of clk_period_meter.
// The master drives enable and the signal under test; the slave reports results.
interface clk_period_meter_if #(
   parameter int unsigned CNT_W = 8
);

   logic             i_en;
   logic             i_sig;
   logic [CNT_W-1:0] o_period;
   logic [CNT_W-1:0] o_high;
   logic             o_valid;
   logic             o_lock;
   logic             o_timeout;

   modport master (
      output i_en,
      output i_sig,
      input  o_period,
      input  o_high,
      input  o_valid,
      input  o_lock,
      input  o_timeout
   );

   modport slave (
      input  i_en,
      input  i_sig,
      output o_period,
      output o_high,
      output o_valid,
      output o_lock,
      output o_timeout
   );

endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the rising-to-rising period and the sampled high
// time of a slow clock-like data signal in units of clk, flags lock when
// consecutive results agree and timeout when the signal stops toggling.
module clk_period_meter #(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   clk_period_meter_if.slave bus
);

   localparam int unsigned       MCNT_W   = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [MCNT_W-1:0] LOCK_TGT = MCNT_W'(LOCK_CNT);
   localparam logic [MCNT_W-1:0] MCNT_ONE = MCNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_MEAS
   } state_t;

   // synchronizer and edge-detect history
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // measurement state
   state_t                 state_q;
   logic [CNT_W-1:0]       pcnt_q;
   logic [CNT_W-1:0]       hcnt_q;
   logic [MCNT_W-1:0]      mcnt_q;

   // registered results
   logic [CNT_W-1:0]       period_q;
   logic [CNT_W-1:0]       high_q;
   logic                   valid_q;
   logic                   lock_q;
   logic                   timeout_q;

   // combinational helpers
   logic                   sig_s;
   logic                   rise;
   logic [CNT_W-1:0]       pcnt_d;
   logic [CNT_W-1:0]       hcnt_d;
   logic [MCNT_W-1:0]      mcnt_d;
   logic                   pair_match;
   logic                   lock_d;

   // Bring i_sig into the clk domain and keep one sample of history for edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_sig};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge detect, saturating counter increments and lock run-length update.
   always_comb begin
      sig_s      = sync_q[SYNC_STAGES-1];
      rise       = sig_s & ~prev_q;
      pcnt_d     = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
      hcnt_d     = (sig_s && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q;
      // pcnt_d is the period that would be reported if this cycle is a rise
      pair_match = (pcnt_d == period_q) && (hcnt_q == high_q);
      if (!pair_match) begin
         mcnt_d = MCNT_ONE;
      end else if (mcnt_q == LOCK_TGT) begin
         mcnt_d = mcnt_q;
      end else begin
         mcnt_d = mcnt_q + MCNT_ONE;
      end
      lock_d     = (mcnt_d >= LOCK_TGT);
   end

   // Measurement FSM with counters and registered result/flag outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pcnt_q    <= '0;
         hcnt_q    <= '0;
         mcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         lock_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!bus.i_en) begin
            // results hold; everything else restarts from scratch
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            mcnt_q    <= '0;
            lock_q    <= 1'b0;
            timeout_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (rise) begin
                     state_q   <= ST_MEAS;
                     pcnt_q    <= '0;
                     hcnt_q    <= CNT_ONE;
                     timeout_q <= 1'b0;
                  end
               end
               ST_MEAS: begin
                  if (rise) begin
                     period_q <= pcnt_d;
                     high_q   <= hcnt_q;
                     valid_q  <= 1'b1;
                     mcnt_q   <= mcnt_d;
                     lock_q   <= lock_d;
                     pcnt_q   <= '0;
                     hcnt_q   <= CNT_ONE;
                  end else if (pcnt_d == CNT_MAX) begin
                     state_q   <= ST_WAIT;
                     timeout_q <= 1'b1;
                     lock_q    <= 1'b0;
                     mcnt_q    <= '0;
                     pcnt_q    <= '0;
                     hcnt_q    <= '0;
                  end else begin
                     pcnt_q <= pcnt_d;
                     hcnt_q <= hcnt_d;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.o_period  = period_q;
   assign bus.o_high    = high_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_lock    = lock_q;
   assign bus.o_timeout = timeout_q;

endmodule
